// File: rtl/alu_loop_ctrl.sv
// rtl/alu_loop_ctrl.sv - counted-loop sequencer driving the reg-file/ALU datapath
// Runs dest = init; while (dest != limit) dest += step; with a step budget.
module alu_loop_ctrl #(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          init_val,
  input  logic [DATA_WIDTH-1:0]          limit_val,
  input  logic [DATA_WIDTH-1:0]          step_val,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] lim_reg,
  input  logic [CNT_WIDTH-1:0]           max_iter,
  input  logic                           EQ,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  output logic                           WE3,
  output logic                           ALUsrc,
  output logic                           ALUctrl,
  output logic [DATA_WIDTH-1:0]          ImmOp,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic                           cfg_err,
  output logic [CNT_WIDTH-1:0]           iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_INIT, S_LIMIT, S_CHECK, S_STEP, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          init_q, init_d;
  logic [DATA_WIDTH-1:0]          limit_q, limit_d;
  logic [DATA_WIDTH-1:0]          step_q, step_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] lim_q, lim_d;
  logic [CNT_WIDTH-1:0]           max_q, max_d;
  logic [CNT_WIDTH-1:0]           iter_q, iter_d;
  logic                           timeout_q, timeout_d;
  logic                           cfg_err_q, cfg_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      init_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
      dest_q    <= '0;
      lim_q     <= '0;
      max_q     <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
      dest_q    <= dest_d;
      lim_q     <= lim_d;
      max_q     <= max_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    limit_d   = limit_q;
    step_d    = step_q;
    dest_d    = dest_q;
    lim_d     = lim_q;
    max_d     = max_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    cfg_err_d = cfg_err_q;
    AD1       = '0;
    AD2       = '0;
    AD3       = '0;
    WE3       = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = 1'b0;
    ImmOp     = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          init_d    = init_val;
          limit_d   = limit_val;
          step_d    = step_val;
          dest_d    = dest_reg;
          lim_d     = lim_reg;
          max_d     = max_iter;
          iter_d    = '0;
          timeout_d = 1'b0;
          // r0 is hardwired zero, and dest/lim must not alias each other
          if (dest_reg == '0 || lim_reg == '0 || dest_reg == lim_reg) begin
            cfg_err_d = 1'b1;
            state_d   = S_ERR;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = S_INIT;
          end
        end
      end
      S_ERR: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_INIT: begin
        busy    = 1'b1;
        AD3     = dest_q;
        ALUsrc  = 1'b1;
        ImmOp   = init_q;
        WE3     = 1'b1;
        state_d = S_LIMIT;
      end
      S_LIMIT: begin
        busy    = 1'b1;
        AD3     = lim_q;
        ALUsrc  = 1'b1;
        ImmOp   = limit_q;
        WE3     = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        busy    = 1'b1;
        AD1     = dest_q;
        AD2     = lim_q;
        ALUctrl = 1'b1;
        // Budget test comes before the STEP increment, so iter never wraps
        if (EQ) begin
          state_d = S_DONE;
        end else if (iter_q == max_q) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        busy    = 1'b1;
        AD1     = dest_q;
        AD3     = dest_q;
        ALUsrc  = 1'b1;
        ImmOp   = step_q;
        WE3     = 1'b1;
        iter_d  = iter_q + 1'b1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign timeout    = timeout_q;
  assign cfg_err    = cfg_err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_alu_loop_ctrl.sv
// tb/tb_alu_loop_ctrl.sv - self-checking bench for alu_loop_ctrl with a reg-file/ALU model
module tb_alu_loop_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] init_val = '0, limit_val = '0, step_val = '0;
  logic [AW-1:0] dest_reg = '0, lim_reg = '0;
  logic [CW-1:0] max_iter = '0;
  logic          EQ;
  logic [AW-1:0] AD1, AD2, AD3;
  logic          WE3, ALUsrc, ALUctrl;
  logic [DW-1:0] ImmOp;
  logic          busy, done, timeout, cfg_err;
  logic [CW-1:0] iter_count;

  alu_loop_ctrl #(.REG_FILE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_val(init_val), .limit_val(limit_val),
    .step_val(step_val), .dest_reg(dest_reg), .lim_reg(lim_reg), .max_iter(max_iter),
    .EQ(EQ), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmOp(ImmOp), .busy(busy), .done(done), .timeout(timeout),
    .cfg_err(cfg_err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Datapath model: reg file (r0 = 0) + operand mux + add/sub ALU
  logic [DW-1:0] rf [32];
  logic [DW-1:0] rd1, rd2, op2, alu_res;
  assign rd1     = (AD1 == '0) ? '0 : rf[AD1];
  assign rd2     = (AD2 == '0) ? '0 : rf[AD2];
  assign op2     = ALUsrc ? ImmOp : rd2;
  assign alu_res = ALUctrl ? (rd1 - op2) : (rd1 + op2);
  assign EQ      = (rd1 == op2);

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk) if (WE3 && AD3 != '0) rf[AD3] <= alu_res;

  typedef struct {
    logic [DW-1:0] init;
    logic [DW-1:0] limit;
    logic [DW-1:0] step;
    logic [AW-1:0] dest;
    logic [AW-1:0] lim;
    logic [CW-1:0] maxi;
    logic [CW-1:0] e_iter;
    logic          e_to;
    logic          e_err;
    logic [DW-1:0] e_reg;
  } vec_t;

  vec_t tbl [10];
  vec_t sb [$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic all_zero_check(input string name);
    check(name, 64'(|{AD1, AD2, AD3, WE3, ALUsrc, ALUctrl, ImmOp, busy, done,
                      timeout, cfg_err, iter_count}), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int   m;
    int   we3n;
    vec_t e;
    sb.push_back(v);
    @(negedge clk);
    init_val = v.init; limit_val = v.limit; step_val = v.step;
    dest_reg = v.dest; lim_reg = v.lim; max_iter = v.maxi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m = 0;
    we3n = 0;
    while (!done && m < 200) begin
      we3n += int'(WE3);
      // A start with garbage config mid-run must be ignored
      if (m == 4) begin
        start = 1'b1; init_val = 32'hDEAD_BEEF; dest_reg = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      m++;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_seen",  64'(done), 64'd1);
    check("latency",    64'(m), e.e_err ? 64'd0 : 64'(3 + 2 * int'(e.e_iter)));
    check("iter_count", 64'(iter_count), 64'(e.e_iter));
    check("timeout",    64'(timeout), 64'(e.e_to));
    check("cfg_err",    64'(cfg_err), 64'(e.e_err));
    check("busy_done",  64'(busy), 64'd1);
    check("we3_cycles", 64'(we3n), e.e_err ? 64'd0 : 64'(2 + int'(e.e_iter)));
    if (!e.e_err) begin
      check("dest_reg_val", 64'(rf[e.dest]), 64'(e.e_reg));
      check("lim_reg_val",  64'(rf[e.lim]), 64'(e.limit));
    end
    @(negedge clk);
    check("done_pulse", 64'({done, busy}), 64'd0);
    check("iter_hold",  64'(iter_count), 64'(e.e_iter));
  endtask

  initial begin
    //          init          limit         step          dst    lim    max     iter   to    err   reg
    tbl[0] = '{32'd0,        32'd5,        32'd1,        5'd10, 5'd11, 16'd100, 16'd5, 1'b0, 1'b0, 32'd5};
    tbl[1] = '{32'd7,        32'd7,        32'd1,        5'd10, 5'd11, 16'd100, 16'd0, 1'b0, 1'b0, 32'd7};
    tbl[2] = '{32'd0,        32'd3,        32'd2,        5'd10, 5'd11, 16'd4,   16'd4, 1'b1, 1'b0, 32'd8};
    tbl[3] = '{32'h7FFFFFFE, 32'h80000000, 32'd1,        5'd10, 5'd11, 16'd100, 16'd2, 1'b0, 1'b0, 32'h80000000};
    tbl[4] = '{32'd0,        32'd0,        32'd0,        5'd5,  5'd5,  16'd100, 16'd0, 1'b0, 1'b1, 32'd0};
    tbl[5] = '{32'd1,        32'd2,        32'd1,        5'd6,  5'd7,  16'd0,   16'd0, 1'b1, 1'b0, 32'd1};
    tbl[6] = '{32'd10,       32'hFFFFFFFE, 32'hFFFFFFFD, 5'd3,  5'd4,  16'd50,  16'd4, 1'b0, 1'b0, 32'hFFFFFFFE};
    tbl[7] = '{32'd1,        32'd2,        32'd1,        5'd0,  5'd7,  16'd10,  16'd0, 1'b0, 1'b1, 32'd0};
    tbl[8] = '{32'd1,        32'd2,        32'd1,        5'd7,  5'd0,  16'd10,  16'd0, 1'b0, 1'b1, 32'd0};
    tbl[9] = '{32'd5,        32'd9,        32'd4,        5'd31, 5'd1,  16'd1,   16'd1, 1'b0, 1'b0, 32'd9};

    #12;
    all_zero_check("reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    all_zero_check("idle_outputs");

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Mid-run reset: catch a STEP cycle, then assert rst asynchronously
    begin
      int k;
      @(negedge clk);
      init_val = 32'd0; limit_val = 32'd5; step_val = 32'd1;
      dest_reg = 5'd10; lim_reg = 5'd11; max_iter = 16'd100;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(WE3 && AD1 == 5'd10 && AD3 == 5'd10) && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("reached_step", 64'(k < 50), 64'd1);
      #2 rst = 1'b1;
      #1 all_zero_check("midrun_reset");
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("start_in_reset", 64'(busy), 64'd0);
      all_zero_check("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 64'(busy), 64'd0);
    end

    run_vec(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
